// File: rtl/decoder_lock_ctrl.sv
// 64b/66b block-lock controller: counts valid sync headers per window, asserts
// block lock after a clean window and requests aligner slips on bad alignment.
module decoder_lock_ctrl #(
  parameter int NB_SYNC_HDR = 2,
  parameter int N_WINDOW    = 64,
  parameter int N_BAD       = 16,
  parameter int N_SLIP_WAIT = 4,
  parameter int NB_LOSS_CNT = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic [NB_SYNC_HDR-1:0] i_sync_header,
  output logic                   o_block_lock,
  output logic                   o_slip,
  output logic                   o_decoder_enable,
  output logic [1:0]             o_state,
  output logic [NB_LOSS_CNT-1:0] o_lock_loss_cnt
);

  localparam int NB_SH_CNT   = $clog2(N_WINDOW + 1);
  localparam int NB_WAIT_CNT = $clog2(N_SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    RESET_CNT = 2'b00,
    TEST_SH   = 2'b01,
    SLIP      = 2'b10,
    ILLEGAL   = 2'b11
  } state_e;

  state_e                 state_q, state_d;
  logic [NB_SH_CNT-1:0]   sh_cnt_q, sh_cnt_d;
  logic [NB_SH_CNT-1:0]   invld_cnt_q, invld_cnt_d;
  logic [NB_WAIT_CNT-1:0] wait_cnt_q, wait_cnt_d;
  logic                   block_lock_q, block_lock_d;
  logic                   slip_q, slip_d;
  logic [NB_LOSS_CNT-1:0] loss_cnt_q, loss_cnt_d;

  logic                   hdr_invalid;
  logic [NB_SH_CNT-1:0]   sh_nxt;
  logic [NB_SH_CNT-1:0]   inv_nxt;
  logic [NB_WAIT_CNT-1:0] wait_nxt;

  assign hdr_invalid = (i_sync_header != NB_SYNC_HDR'(2'b01)) &&
                       (i_sync_header != NB_SYNC_HDR'(2'b10));
  assign sh_nxt      = sh_cnt_q + NB_SH_CNT'(1);
  assign inv_nxt     = invld_cnt_q + NB_SH_CNT'(hdr_invalid);
  assign wait_nxt    = wait_cnt_q + NB_WAIT_CNT'(1);

  // State register and all counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= RESET_CNT;
      sh_cnt_q     <= '0;
      invld_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      block_lock_q <= 1'b0;
      slip_q       <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sh_cnt_q     <= sh_cnt_d;
      invld_cnt_q  <= invld_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      block_lock_q <= block_lock_d;
      slip_q       <= slip_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    // NOTE: every target gets a hold/default value up front so no path
    // through the case leaves a variable unassigned (which would infer a latch).
    state_d      = state_q;
    sh_cnt_d     = sh_cnt_q;
    invld_cnt_d  = invld_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    block_lock_d = block_lock_q;

    case (state_q)
      RESET_CNT: begin
        sh_cnt_d    = '0;
        invld_cnt_d = '0;
        wait_cnt_d  = '0;
        state_d     = TEST_SH;
      end

      TEST_SH: begin
        if (i_enable) begin
          if (block_lock_q && (inv_nxt == NB_SH_CNT'(N_BAD))) begin
            block_lock_d = 1'b0;
            state_d      = SLIP;
          end else if (!block_lock_q && hdr_invalid) begin
            state_d = SLIP;
          end else if (sh_nxt == NB_SH_CNT'(N_WINDOW)) begin
            if (inv_nxt == '0) block_lock_d = 1'b1;
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end else begin
            sh_cnt_d    = sh_nxt;
            invld_cnt_d = inv_nxt;
          end
        end
      end

      SLIP: begin
        // Headers are ignored here; only enabled blocks are counted.
        if (i_enable) begin
          if (wait_nxt == NB_WAIT_CNT'(N_SLIP_WAIT)) begin
            wait_cnt_d = '0;
            state_d    = RESET_CNT;
          end else begin
            wait_cnt_d = wait_nxt;
          end
        end
      end

      default: state_d = RESET_CNT;
    endcase
  end

  // Slip pulse marks only the entry into SLIP; loss counter saturates.
  always_comb begin
    slip_d     = (state_d == SLIP) && (state_q != SLIP);
    loss_cnt_d = loss_cnt_q;
    if (block_lock_q && !block_lock_d && (loss_cnt_q != '1))
      loss_cnt_d = loss_cnt_q + NB_LOSS_CNT'(1);
  end

  // Output process.
  always_comb begin
    o_state          = state_q;
    o_block_lock     = block_lock_q;
    o_slip           = slip_q && !i_reset;
    o_decoder_enable = block_lock_q && i_enable && !i_reset;
    o_lock_loss_cnt  = loss_cnt_q;
  end

endmodule

// File: tb/tb_decoder_lock_ctrl.sv
// Directed bench for decoder_lock_ctrl: acquisition, slip, lock loss,
// tolerated errors, gapped input and reset during a slip.
module tb_decoder_lock_ctrl;

  logic       clk;
  logic       i_reset;
  logic       i_enable;
  logic [1:0] i_sync_header;
  logic       o_block_lock;
  logic       o_slip;
  logic       o_decoder_enable;
  logic [1:0] o_state;
  logic [7:0] o_lock_loss_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int slip_pulses = 0;

  decoder_lock_ctrl dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .i_enable         (i_enable),
    .i_sync_header    (i_sync_header),
    .o_block_lock     (o_block_lock),
    .o_slip           (o_slip),
    .o_decoder_enable (o_decoder_enable),
    .o_state          (o_state),
    .o_lock_loss_cnt  (o_lock_loss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one cycle of stimulus, then sample 1 ns after the rising edge.
  task automatic step(input logic en, input logic [1:0] hdr);
    i_enable      = en;
    i_sync_header = hdr;
    @(posedge clk);
    #1;
    if (o_slip) slip_pulses++;
  endtask

  function automatic logic [1:0] valid_hdr(input int i);
    return (i % 2 != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic do_reset();
    i_reset = 1'b1;
    step(1'b1, 2'b01);
    step(1'b0, 2'b00);
    i_reset = 1'b0;
  endtask

  initial begin
    int base_slips;
    int bad_dec;
    i_reset       = 1'b1;
    i_enable      = 1'b0;
    i_sync_header = 2'b00;

    // Reset state
    do_reset();
    i_reset = 1'b1;
    check("rst_state", o_state, 0);
    check("rst_lock", o_block_lock, 0);
    check("rst_slip", o_slip, 0);
    check("rst_loss", o_lock_loss_cnt, 0);
    i_enable = 1'b1;
    #1 check("rst_dec_en", o_decoder_enable, 0);
    i_reset = 1'b0;
    step(1'b0, 2'b00);
    check("rst_to_test", o_state, 1);

    // Clean acquire
    slip_pulses = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, valid_hdr(i));
      if (i == 62) check("acq_lock_pre", o_block_lock, 0);
    end
    check("acq_lock", o_block_lock, 1);
    check("acq_no_slip", slip_pulses, 0);
    check("acq_dec_en_on", o_decoder_enable, 1);
    i_enable = 1'b0;
    #1 check("acq_dec_en_off", o_decoder_enable, 0);

    // Tolerated errors: 15 invalid headers in each of 3 windows
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 64; i++)
        step(1'b1, (i % 4 == 0 && i < 60) ? ((i % 8 == 0) ? 2'b00 : 2'b11) : valid_hdr(i));
      check($sformatf("tol_lock_w%0d", w), o_block_lock, 1);
      check($sformatf("tol_state_w%0d", w), o_state, 1);
    end
    check("tol_no_slip", slip_pulses, 0);
    check("tol_loss", o_lock_loss_cnt, 0);

    // Lock loss: 16th invalid header at block 60 of the window
    for (int i = 0; i <= 60; i++) begin
      step(1'b1, (i % 4 == 0) ? ((i % 8 == 0) ? 2'b00 : 2'b11) : valid_hdr(i));
      if (i == 56) check("loss_lock_pre", o_block_lock, 1);
    end
    check("loss_lock", o_block_lock, 0);
    check("loss_state", o_state, 2);
    check("loss_slip", o_slip, 1);
    check("loss_slip_cnt", slip_pulses, 1);
    check("loss_cnt", o_lock_loss_cnt, 1);

    // Reset mid-slip
    step(1'b1, 2'b01);
    check("mslip_slip_low", o_slip, 0);
    step(1'b0, 2'b01);
    i_reset = 1'b1;
    #1 check("mslip_rst_slip", o_slip, 0);
    step(1'b1, 2'b00);
    check("mslip_state", o_state, 0);
    check("mslip_lock", o_block_lock, 0);
    check("mslip_loss", o_lock_loss_cnt, 0);
    check("mslip_dec_en", o_decoder_enable, 0);
    check("mslip_slip", o_slip, 0);
    check("mslip_slip_cnt", slip_pulses, 1);
    i_reset = 1'b0;
    step(1'b0, 2'b00);
    check("mslip_to_test", o_state, 1);

    // Misaligned start
    base_slips = slip_pulses;
    step(1'b1, 2'b00);
    check("mis_slip", o_slip, 1);
    check("mis_state_slip", o_state, 2);
    step(1'b1, 2'b01);
    check("mis_slip_one", o_slip, 0);
    step(1'b1, 2'b11);
    step(1'b1, 2'b00);
    step(1'b0, 2'b01);
    check("mis_wait_hold", o_state, 2);
    step(1'b1, 2'b01);
    check("mis_reset_cnt", o_state, 0);
    check("mis_lock_low", o_block_lock, 0);
    step(1'b1, 2'b00);
    check("mis_test", o_state, 1);
    for (int i = 0; i < 64; i++) step(1'b1, valid_hdr(i));
    check("mis_lock", o_block_lock, 1);
    check("mis_slip_total", slip_pulses - base_slips, 1);

    // Gapped input: disabled cycles carry invalid headers that must be ignored
    do_reset();
    step(1'b0, 2'b00);
    bad_dec = 0;
    base_slips = slip_pulses;
    for (int i = 0; i < 128; i++) begin
      step(i % 2 == 0, (i % 2 == 0) ? valid_hdr(i / 2) : 2'b11);
      if (i % 2 != 0 && o_decoder_enable !== 1'b0) bad_dec++;
      if (i == 124) check("gap_lock_pre", o_block_lock, 0);
      if (i == 126) begin
        check("gap_lock", o_block_lock, 1);
        check("gap_dec_en_on", o_decoder_enable, 1);
      end
    end
    check("gap_dec_en_off", bad_dec, 0);
    check("gap_no_slip", slip_pulses - base_slips, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_lock_ctrl.md
DECODER_LOCK_CTRL -- requirements
Module: decoder_lock_ctrl

Interface

REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- NB_SYNC_HDR, 2, sync-header width of a 66-bit coded block.
- N_WINDOW, 64, headers per test window.
- N_BAD, 16, invalid headers in one window that drop lock.
- N_SLIP_WAIT, 4, enabled blocks ignored after a slip while the aligner settles.
- NB_LOSS_CNT, 8, lock-loss counter width.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- i_clock, in, 1, single block clock.
- i_reset, in, 1, synchronous active-high reset.
- i_enable, in, 1, one coded block is present this cycle.
- i_sync_header, in, NB_SYNC_HDR, bits [65:64] of the current coded block.
- o_block_lock, out, 1, block lock achieved.
- o_slip, out, 1, one-cycle request to the block aligner to shift by one bit.
- o_decoder_enable, out, 1, enable for the decoder datapath.
- o_state, out, 2, current FSM state encoding.
- o_lock_loss_cnt, out, NB_LOSS_CNT, count of lock-to-unlock transitions.

REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high, on i_clock and i_reset.

Function

REQ-004 A header SHALL be valid when i_sync_header is 2'b01 or 2'b10. It SHALL be invalid when it is 2'b00 or 2'b11.

REQ-005 The block SHALL evaluate headers only in cycles where i_enable=1. All counters SHALL hold when i_enable=0.

REQ-006 The FSM SHALL have three states:
- RESET_CNT = 2'b00
- TEST_SH = 2'b01
- SLIP = 2'b10
- 2'b11 is illegal and SHALL recover to RESET_CNT on the next cycle.

REQ-007 RESET_CNT SHALL clear sh_cnt and invld_cnt. It SHALL go to TEST_SH on the next cycle unconditionally and SHALL consume no block.

REQ-008 In TEST_SH with i_enable=1, the next-count values SHALL be:
- sh_nxt = sh_cnt + 1
- inv_nxt = invld_cnt + (invalid ? 1 : 0)

REQ-009 In TEST_SH with o_block_lock=0, any invalid header SHALL cause a transition to SLIP.

REQ-010 In TEST_SH with o_block_lock=1 and inv_nxt == N_BAD, the block SHALL clear o_block_lock and transition to SLIP. This rule SHALL take priority over the window-end rule (REQ-011).

REQ-011 In TEST_SH, when sh_nxt == N_WINDOW and no slip is triggered:
- o_block_lock SHALL be set to 1 if inv_nxt == 0, and SHALL otherwise keep its value.
- Both counters SHALL clear.
- The FSM SHALL stay in TEST_SH.

REQ-012 Otherwise in TEST_SH, sh_cnt and invld_cnt SHALL register sh_nxt and inv_nxt.

REQ-013 o_slip SHALL be 1 for exactly the first cycle in SLIP and 0 in every other cycle.

REQ-014 In SLIP, a wait counter SHALL count enabled blocks and ignore their headers. After N_SLIP_WAIT enabled blocks the FSM SHALL go to RESET_CNT.

REQ-015 o_block_lock SHALL stay 0 throughout SLIP and RESET_CNT following a slip.

REQ-016 o_decoder_enable SHALL equal o_block_lock AND i_enable, combinationally, with zero latency.

REQ-017 o_lock_loss_cnt SHALL increment on every 1-to-0 transition of o_block_lock and SHALL saturate at all-ones.

REQ-018 The counter widths SHALL be:
- sh_cnt and invld_cnt: $clog2(N_WINDOW+1) bits.
- wait counter: $clog2(N_SLIP_WAIT+1) bits.

Reset

REQ-019 While i_reset=1, the block SHALL drive:
- state = RESET_CNT
- all counters = 0
- o_block_lock = 0
- o_slip = 0
- o_decoder_enable = 0
- o_lock_loss_cnt = 0

REQ-020 Reset asserted mid-window or mid-slip SHALL abort the operation with no extra o_slip pulse. Reset SHALL take priority over i_enable.

Verification

REQ-021 Clean acquire: reset, then 64 enabled valid headers (2'b01/2'b10 alternating). Required response: o_block_lock rises the cycle after the 64th header; o_slip stays 0.

REQ-022 Misaligned start: first enabled header is 2'b00. Required response:
- o_slip=1 for one cycle.
- 4 blocks are ignored.
- RESET_CNT, then 64 valid headers give lock.

REQ-023 Lock loss: while locked, 16 invalid headers spread within one 64-block window. Required response:
- o_block_lock falls after the 16th invalid header.
- o_slip pulses once.
- o_lock_loss_cnt = 1.

REQ-024 Tolerated errors: while locked, 15 invalid headers in each of 3 consecutive windows. Required response: lock is held, no o_slip pulse, and counters clear at every 64th block.

REQ-025 Gapped input: i_enable toggles 1/0 during acquisition. Required response: counters advance only on enabled cycles; o_decoder_enable = 0 whenever i_enable = 0.

REQ-026 Reset mid-slip: assert i_reset during the SLIP wait. Required response: the next cycle shows state 2'b00 and all outputs 0.
